// File: rtl/dd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dd_pkg                                                                     |
// | Shared types and constants for the 8-lane round-robin merge.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dd_pkg;

    localparam int N_LANES = 8;
    localparam int LANE_W  = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        EOS   = 2'd2
    } merge_state_t;

    // Payload width is a module parameter, so data travels beside this struct.
    typedef struct packed {
        logic [31:0] tag;
        logic [63:0] serialnum;
        logic        was_joined;
        logic        last_processed;
    } tuple_t;

    function automatic logic [LANE_W-1:0] lane_inc(input logic [LANE_W-1:0] lane);
        return lane + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter8                                                                |
// | Combinational round-robin pick: first request at or above ptr, mod 8.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter8
    import dd_pkg::*;
(
    input  logic [N_LANES-1:0] req,
    input  logic [LANE_W-1:0]  ptr,
    output logic [N_LANES-1:0] grant,
    output logic [LANE_W-1:0]  idx
);

    logic [LANE_W-1:0] w_cand;
    logic              w_found;

    // Candidate lanes are visited in rotated order; the 3-bit sum wraps for free.
    always_comb begin
        grant   = '0;
        idx     = ptr;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_LANES; k++) begin
            w_cand = ptr + LANE_W'(k);
            if (!w_found && req[w_cand]) begin
                grant[w_cand] = 1'b1;
                idx           = w_cand;
                w_found       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dd_merge_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dd_merge_rr                                                                |
// | Merges 8 tuple lanes into one registered stream and tracks end-of-stream.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dd_merge_rr #(
    parameter int INPUT_SIZE = 64,
    parameter int N_LANES    = 8
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [N_LANES-1:0]                 in_valid,
    output logic [N_LANES-1:0]                 in_ready,
    input  logic [N_LANES-1:0][INPUT_SIZE-1:0] in_data,
    input  logic [N_LANES-1:0][31:0]           in_tag,
    input  logic [N_LANES-1:0]                 in_last_processed,
    input  logic [N_LANES-1:0][63:0]           in_serialnum,
    input  logic [N_LANES-1:0]                 in_was_joined,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [INPUT_SIZE-1:0]              out_data,
    output logic [31:0]                        out_tag,
    output logic [63:0]                        out_serialnum,
    output logic                               out_was_joined,
    output logic [2:0]                         out_src,
    output logic                               out_last_processed,
    output logic [N_LANES-1:0]                 lanes_done,
    output logic                               all_done
);
    import dd_pkg::*;

    merge_state_t          r_state;
    logic [LANE_W-1:0]     r_ptr;
    logic [N_LANES-1:0]    r_lanes_done;
    logic                  r_out_valid;
    logic [INPUT_SIZE-1:0] r_out_data;
    tuple_t                r_out_meta;
    logic [LANE_W-1:0]     r_out_src;
    logic                  r_all_done;

    logic [N_LANES-1:0]    w_req;
    logic [N_LANES-1:0]    w_grant;
    logic [N_LANES-1:0]    w_accept;
    logic [N_LANES-1:0]    w_done_next;
    logic [LANE_W-1:0]     w_idx;
    logic                  w_space;
    logic                  w_run;
    logic                  w_xfer;
    logic                  w_final;
    tuple_t                w_sel;

    // Lanes that already delivered their last beat are parked until EOS.
    assign w_req = in_valid & ~r_lanes_done;

    rr_arbiter8 u_arb (
        .req   (w_req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign w_space     = ~r_out_valid | out_ready;
    assign w_run       = (r_state == RUN);
    assign in_ready    = (w_run && w_space) ? w_grant : '0;
    assign w_accept    = in_ready & in_valid;
    assign w_xfer      = |w_accept;
    assign w_done_next = r_lanes_done | (w_accept & in_last_processed);
    assign w_final     = w_xfer & (&w_done_next);

    always_comb begin
        w_sel                = '0;
        w_sel.tag            = in_tag[w_idx];
        w_sel.serialnum      = in_serialnum[w_idx];
        w_sel.was_joined     = in_was_joined[w_idx];
        w_sel.last_processed = w_final;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state      <= RUN;
            r_ptr        <= '0;
            r_lanes_done <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_meta   <= '0;
            r_out_src    <= '0;
            r_all_done   <= 1'b0;
        end else begin
            r_all_done <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_xfer) begin
                        r_out_valid  <= 1'b1;
                        r_out_data   <= in_data[w_idx];
                        r_out_meta   <= w_sel;
                        r_out_src    <= w_idx;
                        r_ptr        <= lane_inc(w_idx);
                        r_lanes_done <= w_done_next;
                        if (w_final) begin
                            r_state <= DRAIN;
                        end
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Only the merged final beat is left in the output register.
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_all_done  <= 1'b1;
                        r_state     <= EOS;
                    end
                end
                EOS: begin
                    r_lanes_done <= '0;
                    r_ptr        <= '0;
                    r_state      <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign out_valid          = r_out_valid;
    assign out_data           = r_out_data;
    assign out_tag            = r_out_meta.tag;
    assign out_serialnum      = r_out_meta.serialnum;
    assign out_was_joined     = r_out_meta.was_joined;
    assign out_last_processed = r_out_meta.last_processed;
    assign out_src            = r_out_src;
    assign lanes_done         = r_lanes_done;
    assign all_done           = r_all_done;

    a_ready_onehot: assert property (@(posedge clk) disable iff (resetn) $onehot0(in_ready));

endmodule
`default_nettype wire

// File: tb/tb_dd_merge_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dd_merge_rr                                                             |
// | Self-checking bench for dd_merge_rr against a transaction-level model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dd_merge_rr;

    localparam int W = 64;

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] tag;
        logic [63:0] serial;
        logic        wj;
        logic        last;
        logic [2:0]  src;
    } beat_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic [7:0]        in_valid, in_ready, in_last_processed, in_was_joined, lanes_done;
    logic [7:0][W-1:0] in_data;
    logic [7:0][31:0]  in_tag;
    logic [7:0][63:0]  in_serialnum;
    logic              out_valid, out_ready, out_was_joined, out_last_processed, all_done;
    logic [W-1:0]      out_data;
    logic [31:0]       out_tag;
    logic [63:0]       out_serialnum;
    logic [2:0]        out_src;

    dd_merge_rr #(.INPUT_SIZE(W), .N_LANES(8)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .in_last_processed(in_last_processed), .in_serialnum(in_serialnum),
        .in_was_joined(in_was_joined),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_serialnum(out_serialnum), .out_was_joined(out_was_joined), .out_src(out_src),
        .out_last_processed(out_last_processed), .lanes_done(lanes_done), .all_done(all_done)
    );

    always #5 clk = ~clk;

    // Model: per-lane source queues, expected output queue, done set, rr pointer.
    beat_t      lane_q[8][$];
    beat_t      outq[$];
    logic [7:0] m_done;
    int         m_ptr;
    bit         m_wait_final;
    bit         m_eos;
    logic [7:0] exp_ready;
    bit         exp_valid;
    beat_t      exp_beat;
    int         nchecks = 0;
    int         nerr = 0;

    function automatic beat_t rand_beat(bit last);
        beat_t b;
        b.data   = {$urandom, $urandom};
        b.tag    = $urandom;
        b.serial = {$urandom, $urandom};
        b.wj     = 1'($urandom_range(0, 1));
        b.last   = last;
        b.src    = 3'd0;
        return b;
    endfunction

    function automatic beat_t dut_beat();
        return {out_data, out_tag, out_serialnum, out_was_joined, out_last_processed, out_src};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) lane_q[i].delete();
        outq.delete();
        m_done = '0; m_ptr = 0; m_wait_final = 0; m_eos = 0;
    endtask

    task automatic apply_reset();
        resetn = 1'b1; in_valid = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        model_clear();
    endtask

    // Drive lane heads, then at the falling edge derive what the spec demands.
    task automatic prepare();
        bit found;
        int l;
        for (int i = 0; i < 8; i++) begin
            if (lane_q[i].size() != 0) begin
                in_valid[i] = 1'b1;
                in_data[i] = lane_q[i][0].data;
                in_tag[i] = lane_q[i][0].tag;
                in_serialnum[i] = lane_q[i][0].serial;
                in_was_joined[i] = lane_q[i][0].wj;
                in_last_processed[i] = lane_q[i][0].last;
            end else begin
                in_valid[i] = 1'b0;
                in_data[i] = {$urandom, $urandom};
                in_tag[i] = $urandom;
                in_serialnum[i] = {$urandom, $urandom};
                in_was_joined[i] = 1'($urandom);
                in_last_processed[i] = 1'($urandom);
            end
        end
        @(negedge clk);
        exp_ready = '0;
        found = 0;
        if (!m_wait_final && !m_eos && (outq.size() == 0 || out_ready)) begin
            for (int k = 0; k < 8; k++) begin
                l = (m_ptr + k) % 8;
                if (!found && in_valid[l] && !m_done[l]) begin
                    exp_ready[l] = 1'b1;
                    found = 1;
                end
            end
        end
        exp_valid = (outq.size() != 0);
        exp_beat = '0;
        if (exp_valid) exp_beat = outq[0];
    endtask

    task automatic advance();
        int acc;
        beat_t b;
        logic [7:0] nd;
        acc = -1;
        for (int i = 0; i < 8; i++) if (exp_ready[i] && in_valid[i]) acc = i;
        if (m_eos) begin
            m_eos = 0; m_done = '0; m_ptr = 0;
        end
        if (outq.size() != 0 && out_ready) begin
            b = outq.pop_front();
            if (b.last) begin
                m_wait_final = 0;
                m_eos = 1;
            end
        end
        if (acc >= 0) begin
            b = lane_q[acc].pop_front();
            b.src = 3'(acc);
            nd = m_done;
            nd[acc] = nd[acc] | b.last;
            b.last = b.last && (nd == 8'hFF);
            m_done = nd;
            m_ptr = (acc + 1) % 8;
            m_wait_final = m_wait_final | b.last;
            outq.push_back(b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data[i] = {$urandom, $urandom}; in_tag[i] = $urandom;
            in_serialnum[i] = {$urandom, $urandom};
        end
        in_last_processed = 8'hFF; in_was_joined = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nchecks++;
        if ({out_valid, out_data, out_tag, out_serialnum, out_was_joined, out_src,
             out_last_processed, lanes_done, all_done} !== '0) begin
            nerr++;
            $display("FAIL reset.regs got out_valid=%b data=%h tag=%h done=%h all_done=%b exp all zero",
                     out_valid, out_data, out_tag, lanes_done, all_done);
        end
        @(posedge clk); #1;
        resetn = 1'b0; in_valid = '0;
        model_clear();
        @(negedge clk);
        nchecks++;
        if (in_ready !== 8'h00 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset.idle got in_ready=%h out_valid=%b exp 00/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        logic [2:0] obs[$];
        apply_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) for (int i = 0; i < 8; i++) lane_q[i].push_back(rand_beat(0));
        for (int c = 0; c < 28; c++) begin
            prepare();
            nchecks++; if (in_ready !== exp_ready) begin nerr++; $display("FAIL fair.in_ready t=%0t got=%h exp=%h", $time, in_ready, exp_ready); end
            nchecks++; if (out_valid !== exp_valid) begin nerr++; $display("FAIL fair.out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_valid); end
            if (exp_valid) begin nchecks++; if (dut_beat() !== exp_beat) begin nerr++; $display("FAIL fair.beat t=%0t got=%h exp=%h", $time, dut_beat(), exp_beat); end end
            nchecks++; if ({all_done, lanes_done} !== {m_eos, m_done}) begin nerr++; $display("FAIL fair.done t=%0t got=%b/%h exp=%b/%h", $time, all_done, lanes_done, m_eos, m_done); end
            if (out_valid && out_ready) obs.push_back(out_src);
            advance();
        end
        nchecks++;
        if (obs.size() != 24) begin nerr++; $display("FAIL fair.count got=%0d exp=24", obs.size()); end
        for (int i = 0; i < obs.size(); i++) begin
            nchecks++;
            if (obs[i] !== 3'(i % 8)) begin nerr++; $display("FAIL fair.order beat=%0d got=%0d exp=%0d", i, obs[i], i % 8); end
        end
    endtask

    task automatic test_backpressure();
        beat_t b;
        int hits;
        hits = 0;
        apply_reset();
        b = rand_beat(0); b.tag = 32'hA5A5_0003;
        lane_q[3].push_back(b);
        lane_q[5].push_back(rand_beat(0));
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 6);
            prepare();
            nchecks++; if (in_ready !== exp_ready) begin nerr++; $display("FAIL bp.in_ready t=%0t got=%h exp=%h", $time, in_ready, exp_ready); end
            nchecks++; if (out_valid !== exp_valid) begin nerr++; $display("FAIL bp.out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_valid); end
            if (exp_valid) begin nchecks++; if (dut_beat() !== exp_beat) begin nerr++; $display("FAIL bp.beat t=%0t got=%h exp=%h", $time, dut_beat(), exp_beat); end end
            nchecks++; if ({all_done, lanes_done} !== {m_eos, m_done}) begin nerr++; $display("FAIL bp.done t=%0t got=%b/%h exp=%b/%h", $time, all_done, lanes_done, m_eos, m_done); end
            if (c >= 1 && c <= 5) begin
                nchecks++;
                if (in_ready !== 8'h00) begin nerr++; $display("FAIL bp.full_ready t=%0t got=%h exp=00", $time, in_ready); end
            end
            if (out_valid && out_ready && out_tag == 32'hA5A5_0003) hits++;
            advance();
        end
        nchecks++;
        if (hits != 1) begin nerr++; $display("FAIL bp.once got=%0d deliveries exp=1", hits); end
    endtask

    task automatic test_wrap_skip();
        logic [2:0] obs[$];
        apply_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            lane_q[6].push_back(rand_beat(0));
            lane_q[1].push_back(rand_beat(0));
        end
        for (int c = 0; c < 12; c++) begin
            prepare();
            nchecks++; if (in_ready !== exp_ready) begin nerr++; $display("FAIL wrap.in_ready t=%0t got=%h exp=%h", $time, in_ready, exp_ready); end
            nchecks++; if (out_valid !== exp_valid) begin nerr++; $display("FAIL wrap.out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_valid); end
            if (exp_valid) begin nchecks++; if (dut_beat() !== exp_beat) begin nerr++; $display("FAIL wrap.beat t=%0t got=%h exp=%h", $time, dut_beat(), exp_beat); end end
            if (out_valid && out_ready) obs.push_back(out_src);
            advance();
        end
        nchecks++;
        if (obs.size() != 8) begin nerr++; $display("FAIL wrap.count got=%0d exp=8", obs.size()); end
        for (int i = 1; i < obs.size(); i++) begin
            nchecks++;
            if (obs[i] == obs[i-1] || (obs[i] != 3'd1 && obs[i] != 3'd6))
                begin nerr++; $display("FAIL wrap.alternate beat=%0d got=%0d prev=%0d exp other of 1/6", i, obs[i], obs[i-1]); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 8; i++)
                if (lane_q[i].size() < 2 && $urandom_range(0, 2) == 0)
                    lane_q[i].push_back(rand_beat($urandom_range(0, 7) == 0));
            out_ready = ($urandom_range(0, 3) != 0);
            prepare();
            nchecks++; if (in_ready !== exp_ready) begin nerr++; $display("FAIL rand.in_ready t=%0t got=%h exp=%h", $time, in_ready, exp_ready); end
            nchecks++; if (out_valid !== exp_valid) begin nerr++; $display("FAIL rand.out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_valid); end
            if (exp_valid) begin nchecks++; if (dut_beat() !== exp_beat) begin nerr++; $display("FAIL rand.beat t=%0t got=%h exp=%h", $time, dut_beat(), exp_beat); end end
            nchecks++; if ({all_done, lanes_done} !== {m_eos, m_done}) begin nerr++; $display("FAIL rand.done t=%0t got=%b/%h exp=%b/%h", $time, all_done, lanes_done, m_eos, m_done); end
            advance();
        end
    endtask

    task automatic test_end_of_stream();
        int ord[8] = '{5, 2, 7, 0, 1, 3, 4, 6};
        int ord_i, pending, total, lasts, pulses;
        logic [2:0] last_src;
        ord_i = 0; total = 0; lasts = 0; pulses = 0; last_src = '0;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) lane_q[i].push_back(rand_beat(0));
        for (int c = 0; c < 60; c++) begin
            pending = 0;
            for (int i = 0; i < 8; i++) pending += lane_q[i].size();
            if (ord_i < 8 && pending == 0) begin
                lane_q[ord[ord_i]].push_back(rand_beat(1));
                ord_i++;
            end
            prepare();
            nchecks++; if (in_ready !== exp_ready) begin nerr++; $display("FAIL eos.in_ready t=%0t got=%h exp=%h", $time, in_ready, exp_ready); end
            nchecks++; if (out_valid !== exp_valid) begin nerr++; $display("FAIL eos.out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_valid); end
            if (exp_valid) begin nchecks++; if (dut_beat() !== exp_beat) begin nerr++; $display("FAIL eos.beat t=%0t got=%h exp=%h", $time, dut_beat(), exp_beat); end end
            nchecks++; if ({all_done, lanes_done} !== {m_eos, m_done}) begin nerr++; $display("FAIL eos.done t=%0t got=%b/%h exp=%b/%h", $time, all_done, lanes_done, m_eos, m_done); end
            if (out_valid && out_ready) begin
                total++;
                if (out_last_processed) begin lasts++; last_src = out_src; end
            end
            if (all_done) pulses++;
            advance();
        end
        nchecks++; if (ord_i != 8) begin nerr++; $display("FAIL eos.timeout got=%0d lanes fed exp=8", ord_i); end
        nchecks++; if (total != 16) begin nerr++; $display("FAIL eos.beats got=%0d exp=16", total); end
        nchecks++; if (lasts != 1 || last_src !== 3'd6) begin nerr++; $display("FAIL eos.last got=%0d lasts src=%0d exp=1 src=6", lasts, last_src); end
        nchecks++; if (pulses != 1) begin nerr++; $display("FAIL eos.all_done got=%0d pulses exp=1", pulses); end
        nchecks++; if (lanes_done !== 8'h00) begin nerr++; $display("FAIL eos.cleared got=%h exp=00", lanes_done); end
    endtask

    task automatic test_done_gating();
        beat_t b;
        bit seen_done;
        int got99;
        seen_done = 0; got99 = 0;
        apply_reset();
        lane_q[2].push_back(rand_beat(1));
        b = rand_beat(0); b.serial = 64'd99;
        lane_q[2].push_back(b);
        for (int c = 0; c < 60; c++) begin
            if (c == 4) for (int i = 0; i < 8; i++) if (i != 2) lane_q[i].push_back(rand_beat(1));
            out_ready = ($urandom_range(0, 3) != 0);
            prepare();
            nchecks++; if (in_ready !== exp_ready) begin nerr++; $display("FAIL gate.in_ready t=%0t got=%h exp=%h", $time, in_ready, exp_ready); end
            nchecks++; if (out_valid !== exp_valid) begin nerr++; $display("FAIL gate.out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_valid); end
            if (exp_valid) begin nchecks++; if (dut_beat() !== exp_beat) begin nerr++; $display("FAIL gate.beat t=%0t got=%h exp=%h", $time, dut_beat(), exp_beat); end end
            nchecks++; if ({all_done, lanes_done} !== {m_eos, m_done}) begin nerr++; $display("FAIL gate.done t=%0t got=%b/%h exp=%b/%h", $time, all_done, lanes_done, m_eos, m_done); end
            if (all_done) seen_done = 1;
            if (!seen_done && lane_q[2].size() != 0 && lane_q[2][0].serial == 64'd99) begin
                nchecks++;
                if (in_ready[2] !== 1'b0) begin nerr++; $display("FAIL gate.lane2_ready t=%0t got=%b exp=0", $time, in_ready[2]); end
            end
            if (out_valid && out_ready && out_serialnum == 64'd99) begin
                got99++;
                nchecks++;
                if (!seen_done) begin nerr++; $display("FAIL gate.early t=%0t got serial 99 before all_done exp after", $time); end
            end
            advance();
        end
        nchecks++;
        if (got99 != 1) begin nerr++; $display("FAIL gate.serial99 got=%0d deliveries exp=1", got99); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) lane_q[i].push_back(rand_beat(1));
        for (int c = 0; c < 7; c++) begin
            if (c == 5) begin
                lane_q[4].push_back(rand_beat(0));
                out_ready = 1'b0;
            end
            prepare();
            nchecks++; if (in_ready !== exp_ready) begin nerr++; $display("FAIL rstm.in_ready t=%0t got=%h exp=%h", $time, in_ready, exp_ready); end
            nchecks++; if (out_valid !== exp_valid) begin nerr++; $display("FAIL rstm.out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_valid); end
            if (exp_valid) begin nchecks++; if (dut_beat() !== exp_beat) begin nerr++; $display("FAIL rstm.beat t=%0t got=%h exp=%h", $time, dut_beat(), exp_beat); end end
            advance();
        end
        nchecks++;
        if (out_valid !== 1'b1 || lanes_done !== 8'h0F) begin
            nerr++; $display("FAIL rstm.pre got out_valid=%b lanes_done=%h exp 1/0f", out_valid, lanes_done);
        end
        apply_reset();
        nchecks++;
        if ({out_valid, lanes_done, all_done} !== 10'd0) begin
            nerr++; $display("FAIL rstm.post got out_valid=%b lanes_done=%h all_done=%b exp 0/00/0", out_valid, lanes_done, all_done);
        end
        out_ready = 1'b1;
        lane_q[7].push_back(rand_beat(0));
        lane_q[1].push_back(rand_beat(0));
        for (int c = 0; c < 4; c++) begin
            prepare();
            if (c == 0) begin
                nchecks++;
                if (in_ready !== 8'h02) begin nerr++; $display("FAIL rstm.restart got=%h exp=02", in_ready); end
            end
            nchecks++; if (in_ready !== exp_ready) begin nerr++; $display("FAIL rstm.in_ready2 t=%0t got=%h exp=%h", $time, in_ready, exp_ready); end
            nchecks++; if (out_valid !== exp_valid) begin nerr++; $display("FAIL rstm.out_valid2 t=%0t got=%b exp=%b", $time, out_valid, exp_valid); end
            if (exp_valid) begin nchecks++; if (dut_beat() !== exp_beat) begin nerr++; $display("FAIL rstm.beat2 t=%0t got=%h exp=%h", $time, dut_beat(), exp_beat); end end
            advance();
        end
    endtask

    initial begin
        resetn = 1'b1; in_valid = '0; out_ready = 1'b0;
        in_data = '0; in_tag = '0; in_serialnum = '0;
        in_last_processed = '0; in_was_joined = '0;
        model_clear();
        test_reset();
        test_fairness();
        test_backpressure();
        test_wrap_skip();
        test_end_of_stream();
        test_done_gating();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
